// File: rtl/helix_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Package : helix_pkg
// Description : Shared constants for the helix datapath.
// Revision : 1.0 - initial release
// ============================================================================
package helix_pkg;
    localparam int ACTION_W = 16;
endpackage

// ============================================================================
// Module : helix_lane_scheduler
// Description : Round-robin merge of NUM_LANES valid/ready action lanes into
//               one registered output slot, with per-lane precision-mode
//               counters and a total handshake counter.
// Ports :
//   clk            - sole clock, rising edge
//   rst            - synchronous active-high reset
//   lane_valid     - per-lane action offer          [NUM_LANES]
//   lane_ready     - per-lane accept                [NUM_LANES]
//   lane_data      - lane i payload at [i*ACTION_W +: ACTION_W]
//   action_valid   - merged action available
//   action_ready   - downstream accept
//   action_data    - merged action payload          [ACTION_W]
//   action_lane    - source lane of action_data     [LANE_W]
//   prec_clear     - per-lane precision clear       [NUM_LANES]
//   precision_mode - lane i mode at [i*PREC_W +: PREC_W]
//   action_count   - completed output handshakes    [16], wraps
// Revision : 1.0 - initial release
// ============================================================================
module helix_lane_scheduler #(
    parameter int NUM_LANES = 4,
    parameter int ACTION_W  = helix_pkg::ACTION_W,
    parameter int PREC_W    = 2,
    parameter int PREC_SAT  = 0,
    localparam int LANE_W   = ($clog2(NUM_LANES) > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_LANES-1:0]          lane_valid,
    output logic [NUM_LANES-1:0]          lane_ready,
    input  logic [NUM_LANES*ACTION_W-1:0] lane_data,
    output logic                          action_valid,
    input  logic                          action_ready,
    output logic [ACTION_W-1:0]           action_data,
    output logic [LANE_W-1:0]             action_lane,
    input  logic [NUM_LANES-1:0]          prec_clear,
    output logic [NUM_LANES*PREC_W-1:0]   precision_mode,
    output logic [15:0]                   action_count
);

    localparam logic [LANE_W:0]   c_num_lanes = (LANE_W+1)'(NUM_LANES);
    localparam logic [LANE_W-1:0] c_last_lane = LANE_W'(NUM_LANES-1);
    localparam logic [PREC_W-1:0] c_prec_max  = '1;

    logic                 r_valid;
    logic [ACTION_W-1:0]  r_data;
    logic [LANE_W-1:0]    r_lane;
    logic [LANE_W-1:0]    r_rr_ptr;
    logic [15:0]          r_count;
    logic [PREC_W-1:0]    r_prec [NUM_LANES];

    logic                 w_out_free;
    logic                 w_out_hs;
    logic                 w_found;
    logic                 w_accept;
    logic [LANE_W-1:0]    w_grant;
    logic [LANE_W-1:0]    w_next_ptr;
    logic [LANE_W:0]      w_idx;
    logic [ACTION_W-1:0]  w_grant_data;
    logic [NUM_LANES-1:0] w_lane_ready;

    assign w_out_free = !r_valid || action_ready;
    assign w_out_hs   = r_valid && action_ready;

    // Round-robin search: walk offsets 0..N-1 from rr_ptr, folding the lane
    // index back into range so no modulo operator is needed.
    always_comb begin
        w_found = 1'b0;
        w_grant = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (LANE_W+1)'(k);
            if (w_idx >= c_num_lanes) begin
                w_idx = w_idx - c_num_lanes;
            end
            if (!w_found && lane_valid[w_idx[LANE_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = w_idx[LANE_W-1:0];
            end
        end
    end

    // Reset gates acceptance so nothing is taken (or signalled) during rst.
    assign w_accept   = w_found && w_out_free && !rst;
    assign w_next_ptr = (w_grant == c_last_lane) ? '0 : w_grant + 1'b1;

    // Only the granted lane's payload is ever looked at.
    always_comb begin
        w_grant_data = '0;
        w_lane_ready = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (w_grant == LANE_W'(i)) begin
                w_grant_data    = lane_data[i*ACTION_W +: ACTION_W];
                w_lane_ready[i] = w_accept;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_lane   <= '0;
            r_rr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // A new accept refills the slot in the same cycle it drains.
            if (w_accept) begin
                r_valid  <= 1'b1;
                r_data   <= w_grant_data;
                r_lane   <= w_grant;
                r_rr_ptr <= w_next_ptr;
            end else if (w_out_hs) begin
                r_valid  <= 1'b0;
            end
            if (w_out_hs) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    generate
        for (genvar i = 0; i < NUM_LANES; i++) begin : g_prec
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_prec[i] <= '0;
                end else if (prec_clear[i]) begin
                    r_prec[i] <= '0;
                end else if (w_out_hs && (r_lane == LANE_W'(i))) begin
                    if (r_prec[i] == c_prec_max) begin
                        r_prec[i] <= (PREC_SAT != 0) ? c_prec_max : '0;
                    end else begin
                        r_prec[i] <= r_prec[i] + 1'b1;
                    end
                end
            end
            assign precision_mode[i*PREC_W +: PREC_W] = r_prec[i];
        end
    endgenerate

    assign lane_ready   = w_lane_ready;
    assign action_valid = r_valid;
    assign action_data  = r_data;
    assign action_lane  = r_lane;
    assign action_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_helix_lane_scheduler.sv
`default_nettype none
// ============================================================================
// Module : tb_helix_lane_scheduler
// Description : Directed self-checking bench for helix_lane_scheduler with
//               NUM_LANES=4, ACTION_W=16, PREC_W=2. A wrap instance and a
//               saturate instance share all inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_helix_lane_scheduler;

    logic        clk;
    logic        rst;
    logic [3:0]  lane_valid;
    logic [63:0] lane_data;
    logic        action_ready;
    logic [3:0]  prec_clear;

    logic [3:0]  lane_ready;
    logic        action_valid;
    logic [15:0] action_data;
    logic [1:0]  action_lane;
    logic [7:0]  prec_w;
    logic [15:0] action_count;

    logic [3:0]  s_lane_ready;
    logic        s_action_valid;
    logic [15:0] s_action_data;
    logic [1:0]  s_action_lane;
    logic [7:0]  prec_s;
    logic [15:0] s_action_count;

    int n_total;
    int n_bad;

    helix_lane_scheduler #(.NUM_LANES(4), .ACTION_W(16), .PREC_W(2), .PREC_SAT(0)) dut (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_ready(lane_ready),
        .lane_data(lane_data), .action_valid(action_valid), .action_ready(action_ready),
        .action_data(action_data), .action_lane(action_lane), .prec_clear(prec_clear),
        .precision_mode(prec_w), .action_count(action_count)
    );

    helix_lane_scheduler #(.NUM_LANES(4), .ACTION_W(16), .PREC_W(2), .PREC_SAT(1)) dut_sat (
        .clk(clk), .rst(rst), .lane_valid(lane_valid), .lane_ready(s_lane_ready),
        .lane_data(lane_data), .action_valid(s_action_valid), .action_ready(action_ready),
        .action_data(s_action_data), .action_lane(s_action_lane), .prec_clear(prec_clear),
        .precision_mode(prec_s), .action_count(s_action_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; lane_valid = 4'hF; action_ready = 1'b0; prec_clear = 4'h0;
        lane_data = 64'h0004_0003_0002_0001;
        tick(); tick();
        n_total++;
        if (action_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", action_valid); end
        n_total++;
        if (action_data !== 16'h0 || action_lane !== 2'd0) begin n_bad++;
            $display("FAIL reset_data: got data=%h lane=%0d want 0/0", action_data, action_lane); end
        n_total++;
        if (action_count !== 16'h0 || prec_w !== 8'h0 || prec_s !== 8'h0) begin n_bad++;
            $display("FAIL reset_counters: got count=%h prec=%h/%h want 0", action_count, prec_w, prec_s); end
        n_total++;
        if (lane_ready !== 4'h0) begin n_bad++; $display("FAIL reset_lane_ready: got %b want 0000", lane_ready); end
    endtask

    // First accept in the first cycle out of reset, then a 3-cycle stall.
    task automatic test_hold;
        rst = 1'b0; lane_valid = 4'b0100; action_ready = 1'b0;
        lane_data = 64'h0000_00A5_0000_0000;
        #1;
        n_total++;
        if (lane_ready !== 4'b0100) begin n_bad++; $display("FAIL first_grant: got %b want 0100", lane_ready); end
        tick();
        n_total++;
        if (action_valid !== 1'b1 || action_data !== 16'h00A5 || action_lane !== 2'd2) begin n_bad++;
            $display("FAIL first_accept: got v=%b d=%h l=%0d want 1/00a5/2", action_valid, action_data, action_lane); end
        lane_data = 64'h0000_1234_0000_0000;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_total++;
            if (lane_ready !== 4'h0) begin n_bad++; $display("FAIL stall_ready: cycle %0d got %b want 0000", c, lane_ready); end
            tick();
            n_total++;
            if (action_valid !== 1'b1 || action_data !== 16'h00A5 || action_lane !== 2'd2) begin n_bad++;
                $display("FAIL stall_hold: cycle %0d got v=%b d=%h l=%0d want 1/00a5/2", c, action_valid, action_data, action_lane); end
        end
        action_ready = 1'b1; lane_valid = 4'h0;
        tick();
        n_total++;
        if (action_valid !== 1'b0 || action_count !== 16'd1) begin n_bad++;
            $display("FAIL stall_release: got v=%b count=%0d want 0/1", action_valid, action_count); end
        n_total++;
        if (prec_w !== 8'h10) begin n_bad++; $display("FAIL stall_prec: got %h want 10", prec_w); end
    endtask

    task automatic test_round_robin;
        rst = 1'b1; lane_valid = 4'h0; action_ready = 1'b0;
        tick();
        rst = 1'b0; lane_valid = 4'hF; action_ready = 1'b1;
        lane_data = 64'h1003_1002_1001_1000;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_total++;
            if (action_valid !== 1'b1 || action_lane !== 2'(k % 4) || action_data !== 16'h1000 + 16'(k % 4)) begin n_bad++;
                $display("FAIL rr_seq: step %0d got v=%b l=%0d d=%h want 1/%0d/%h", k, action_valid, action_lane,
                         action_data, k % 4, 16'h1000 + 16'(k % 4)); end
        end
        lane_valid = 4'h0;
        tick();
        n_total++;
        if (action_valid !== 1'b0 || action_count !== 16'd5) begin n_bad++;
            $display("FAIL rr_count: got v=%b count=%0d want 0/5", action_valid, action_count); end
        n_total++;
        if (prec_w !== 8'h56 || prec_s !== 8'h56) begin n_bad++;
            $display("FAIL rr_prec: got %h/%h want 56/56", prec_w, prec_s); end
    endtask

    task automatic test_rr_pointer;
        rst = 1'b1; tick();
        rst = 1'b0; lane_valid = 4'b1000; action_ready = 1'b1;
        lane_data = 64'h3333_2222_1111_0000;
        #1;
        n_total++;
        if (lane_ready !== 4'b1000) begin n_bad++; $display("FAIL rr_only3: got %b want 1000", lane_ready); end
        tick();
        n_total++;
        if (action_lane !== 2'd3 || action_data !== 16'h3333) begin n_bad++;
            $display("FAIL rr_only3_out: got l=%0d d=%h want 3/3333", action_lane, action_data); end
        lane_valid = 4'b1001;
        #1;
        n_total++;
        if (lane_ready !== 4'b0001) begin n_bad++; $display("FAIL rr_wrap0: got %b want 0001", lane_ready); end
        tick();
        n_total++;
        if (action_lane !== 2'd0) begin n_bad++; $display("FAIL rr_wrap0_out: got %0d want 0", action_lane); end
        #1;
        n_total++;
        if (lane_ready !== 4'b1000) begin n_bad++; $display("FAIL rr_then3: got %b want 1000", lane_ready); end
        tick();
        n_total++;
        if (action_lane !== 2'd3) begin n_bad++; $display("FAIL rr_then3_out: got %0d want 3", action_lane); end
        lane_valid = 4'h0;
        tick();
    endtask

    task automatic test_precision;
        logic [1:0] exp_w [5];
        logic [1:0] exp_s [5];
        exp_w = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        exp_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        rst = 1'b1; tick();
        rst = 1'b0; lane_valid = 4'b0010; action_ready = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            if (k == 4) lane_valid = 4'h0;
            tick();
            n_total++;
            if (prec_w[3:2] !== exp_w[k] || prec_s[3:2] !== exp_s[k]) begin n_bad++;
                $display("FAIL prec_step: hs %0d got wrap=%0d sat=%0d want %0d/%0d", k + 1,
                         prec_w[3:2], prec_s[3:2], exp_w[k], exp_s[k]); end
        end
    endtask

    task automatic test_clear;
        rst = 1'b1; tick();
        rst = 1'b0; lane_valid = 4'b0010; action_ready = 1'b1;
        tick(); tick();
        lane_valid = 4'h0;
        tick();
        n_total++;
        if (prec_w[3:2] !== 2'd2) begin n_bad++; $display("FAIL clear_setup: got %0d want 2", prec_w[3:2]); end
        lane_valid = 4'b0010;
        tick();
        lane_valid = 4'h0; prec_clear = 4'b0010;
        tick();
        prec_clear = 4'h0;
        n_total++;
        if (prec_w[3:2] !== 2'd0 || prec_s[3:2] !== 2'd0 || action_count !== 16'd3) begin n_bad++;
            $display("FAIL clear_priority: got mode=%0d/%0d count=%0d want 0/0/3", prec_w[3:2], prec_s[3:2], action_count); end
    endtask

    task automatic test_reset_mid;
        lane_valid = 4'b0001; action_ready = 1'b0;
        lane_data = 64'h0000_0000_0000_0BEE;
        tick();
        n_total++;
        if (action_valid !== 1'b1 || action_data !== 16'h0BEE) begin n_bad++;
            $display("FAIL rstmid_setup: got v=%b d=%h want 1/0bee", action_valid, action_data); end
        rst = 1'b1; action_ready = 1'b1;
        #1;
        n_total++;
        if (lane_ready !== 4'h0) begin n_bad++; $display("FAIL rstmid_ready: got %b want 0000", lane_ready); end
        tick();
        n_total++;
        if (action_valid !== 1'b0 || action_count !== 16'd0 || action_data !== 16'h0 || prec_w !== 8'h0) begin n_bad++;
            $display("FAIL rstmid_discard: got v=%b count=%0d d=%h prec=%h want 0/0/0/0", action_valid,
                     action_count, action_data, prec_w); end
        rst = 1'b0; lane_valid = 4'h0; action_ready = 1'b0;
        tick();
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        test_reset();
        test_hold();
        test_round_robin();
        test_rr_pointer();
        test_precision();
        test_clear();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/helix_lane_scheduler.md
HELIX_LANE_SCHEDULER -- requirements
Module: helix_lane_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_LANES, default 4, meaning the number of action lanes (legal range 2..16).
REQ-002 The block SHALL have parameter ACTION_W, default helix_pkg::ACTION_W, meaning the action payload width.
REQ-003 The block SHALL have parameter PREC_W, default 2, meaning the width of each per-lane precision mode.
REQ-004 The block SHALL have parameter PREC_SAT, default 0, meaning precision overflow mode: 0 = wrap, 1 = saturate.
REQ-005 The block SHALL derive LANE_W = max(1, $clog2(NUM_LANES)) and SHALL NOT expose it as a port.
REQ-006 The block SHALL use one clock and a synchronous, active-high reset.
REQ-007 clk  input  1  sole clock; all state updates on its rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 lane_valid  input  NUM_LANES  per-lane action offer.
REQ-010 lane_ready  output  NUM_LANES  per-lane accept.
REQ-011 lane_data  input  NUM_LANES*ACTION_W  lane i payload in bits [i*ACTION_W +: ACTION_W].
REQ-012 action_valid  output  1  merged action available.
REQ-013 action_ready  input  1  downstream accept.
REQ-014 action_data  output  ACTION_W  merged action payload.
REQ-015 action_lane  output  LANE_W  source lane of action_data.
REQ-016 prec_clear  input  NUM_LANES  per-lane precision clear request.
REQ-017 precision_mode  output  NUM_LANES*PREC_W  lane i mode in bits [i*PREC_W +: PREC_W].
REQ-018 action_count  output  16  total completed output handshakes.

Function
REQ-019 Output stage SHALL be a single register slot; out_free = !action_valid || action_ready.
REQ-020 Arbitration SHALL be round-robin: grant = first lane i with lane_valid[i], searched from rr_ptr upward, wrapping at NUM_LANES-1 -> 0.
REQ-021 lane_ready[i] SHALL be 1 only when out_free and i is the granted lane; at most one lane_ready bit high per cycle.
REQ-022 On accept (lane_valid[g] && lane_ready[g]), next cycle SHALL show action_valid=1, action_data=lane g payload, action_lane=g: one-cycle latency.
REQ-023 On accept, rr_ptr SHALL become (g+1) mod NUM_LANES; with no accept, rr_ptr SHALL hold.
REQ-024 If action_valid && action_ready with no new accept, action_valid SHALL drop to 0 next cycle.
REQ-025 Simultaneous output handshake and new accept SHALL keep action_valid=1 with new data: full throughput, no bubble.
REQ-026 While action_valid && !action_ready, action_data and action_lane SHALL hold stable and all lane_ready SHALL be 0.
REQ-027 On each output handshake, precision_mode of lane action_lane SHALL increment by 1.
REQ-028 At all-ones, an increment SHALL wrap to 0 when PREC_SAT=0 and SHALL hold at all-ones when PREC_SAT=1.
REQ-029 prec_clear[i] SHALL set lane i mode to 0 next cycle and SHALL take priority over a same-cycle increment.
REQ-030 action_count SHALL increment by 1 per output handshake and SHALL wrap 0xFFFF -> 0x0000.
REQ-031 Lane payloads of non-granted lanes SHALL be ignored and SHALL NOT affect state.

Reset
REQ-032 While rst=1: action_valid=0, action_data=0, action_lane=0, all precision_mode=0, action_count=0, rr_ptr=0, all lane_ready=0.
REQ-033 rst asserted mid-transfer SHALL discard the held action; no handshake SHALL be reported for the reset cycle.
REQ-034 First accept after reset release SHALL be possible in the first cycle with rst=0.

Verification
REQ-035 NUM_LANES=4, all lanes valid, action_ready=1 -> action_lane sequence 0,1,2,3,0 on consecutive cycles, action_count=5.
REQ-036 Lane 2 valid with data 0x00A5, action_ready=0 for 3 cycles -> action_valid=1, data 0x00A5, lane 2 held; lane_ready all 0; then one handshake.
REQ-037 PREC_W=2, PREC_SAT=0, 5 handshakes from lane 1 -> lane 1 mode 1,2,3,0,1; PREC_SAT=1 -> 1,2,3,3,3.
REQ-038 prec_clear[1]=1 in the same cycle as a lane-1 output handshake with mode 2 -> lane 1 mode=0 next cycle.
REQ-039 Only lane 3 valid after rr_ptr=0 -> grant lane 3, rr_ptr=0 next; then lanes 0 and 3 valid -> lane 0 granted first.
REQ-040 rst pulse while action_valid=1, action_ready=0 -> action_valid=0, counters 0 next cycle; no handshake counted.
